// File: rtl/gpr_sb_pkg.sv
// gpr_sb_pkg: shared constants and helpers for the GPR file with scoreboard.
`default_nettype none

package gpr_sb_pkg;

  localparam int GPR_REG_NUM    = 32;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_X0         = 0;

  // One extra bit so the counter can hold the pending total without wrapping.
  function automatic int pend_cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpr_sb_pend.sv
// gpr_sb_pend: pending-destination bit vector and its popcount-tracking counter.
`default_nettype none

module gpr_sb_pend
  import gpr_sb_pkg::*;
#(
  parameter int REG_NUM    = GPR_REG_NUM,
  parameter int ADDR_WIDTH = GPR_ADDR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  set_en,
  input  logic [ADDR_WIDTH-1:0]                 set_id,
  input  logic                                  clr_en,
  input  logic [ADDR_WIDTH-1:0]                 clr_id,
  output logic [REG_NUM-1:0]                    pend,
  output logic [pend_cnt_width(ADDR_WIDTH)-1:0] cnt
);

  localparam int CNT_W = pend_cnt_width(ADDR_WIDTH);

  logic inc;
  logic dec;

  // A clear on the same id as a set is swallowed: the bit stays 1.
  always_comb begin
    inc = set_en & ~pend[set_id];
    dec = clr_en & pend[clr_id] & ~(set_en & (set_id == clr_id));
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      if (clr_en) pend[clr_id] <= 1'b0;
      if (set_en) pend[set_id] <= 1'b1;
      case ({inc, dec})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpr_sb.sv
// gpr_sb: register file with writeback bypass and RAW/WAW scoreboard stall.
`default_nettype none

module gpr_sb
  import gpr_sb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = GPR_REG_NUM,
  parameter int ADDR_WIDTH = GPR_ADDR_WIDTH
) (
  input  logic                                  i_sys_clk,
  input  logic                                  i_sys_rst,
  input  logic                                  i_sys_flush,
  input  logic                                  i_wbu_valid,
  output logic                                  o_wbu_ready,
  input  logic                                  i_wbu_gpr_wr_en,
  input  logic [ADDR_WIDTH-1:0]                 i_wbu_gpr_wr_id,
  input  logic [DATA_WIDTH-1:0]                 i_wbu_gpr_wr_data,
  input  logic [ADDR_WIDTH-1:0]                 i_idu_gpr_rd_id_1,
  input  logic [ADDR_WIDTH-1:0]                 i_idu_gpr_rd_id_2,
  output logic [DATA_WIDTH-1:0]                 o_idu_gpr_rd_data_1,
  output logic [DATA_WIDTH-1:0]                 o_idu_gpr_rd_data_2,
  input  logic                                  i_idu_issue_valid,
  input  logic                                  i_idu_issue_wr_en,
  input  logic [ADDR_WIDTH-1:0]                 i_idu_issue_wr_id,
  output logic                                  o_idu_stall,
  output logic [pend_cnt_width(ADDR_WIDTH)-1:0] o_gpr_pend_cnt
);

  localparam logic [ADDR_WIDTH-1:0] X0_ID = ADDR_WIDTH'(GPR_X0);

  logic                  ready;
  logic                  commit;
  logic                  wr;
  logic                  accept;
  logic                  set_en;
  logic                  busy_1;
  logic                  busy_2;
  logic                  busy_d;
  logic                  stall;
  logic [REG_NUM-1:0]    pend;
  logic [DATA_WIDTH-1:0] regs [REG_NUM];

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) ready <= 1'b0;
    else           ready <= 1'b1;
  end

  always_comb begin
    commit = i_wbu_valid & ready;
    wr     = commit & i_wbu_gpr_wr_en & (i_wbu_gpr_wr_id != X0_ID);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wr) begin
      regs[i_wbu_gpr_wr_id] <= i_wbu_gpr_wr_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] id);
    if (id == X0_ID)                   return '0;
    else if (wr && id == i_wbu_gpr_wr_id) return i_wbu_gpr_wr_data;
    else                               return regs[id];
  endfunction

  // A destination being written back this cycle is no longer a hazard.
  function automatic logic busy(input logic [ADDR_WIDTH-1:0] id);
    return pend[id] & (id != X0_ID) & ~(wr & (i_wbu_gpr_wr_id == id));
  endfunction

  always_comb begin
    o_idu_gpr_rd_data_1 = read_reg(i_idu_gpr_rd_id_1);
    o_idu_gpr_rd_data_2 = read_reg(i_idu_gpr_rd_id_2);
    busy_1 = busy(i_idu_gpr_rd_id_1);
    busy_2 = busy(i_idu_gpr_rd_id_2);
    busy_d = i_idu_issue_wr_en & busy(i_idu_issue_wr_id);
    stall  = i_idu_issue_valid & (busy_1 | busy_2 | busy_d);
    accept = i_idu_issue_valid & ~stall & ~i_sys_flush;
    set_en = accept & i_idu_issue_wr_en & (i_idu_issue_wr_id != X0_ID);
  end

  gpr_sb_pend #(
    .REG_NUM    (REG_NUM),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pend (
    .clk    (i_sys_clk),
    .rst    (i_sys_rst),
    .flush  (i_sys_flush),
    .set_en (set_en),
    .set_id (i_idu_issue_wr_id),
    .clr_en (wr),
    .clr_id (i_wbu_gpr_wr_id),
    .pend   (pend),
    .cnt    (o_gpr_pend_cnt)
  );

  assign o_wbu_ready = ready;
  assign o_idu_stall = stall;

endmodule

`default_nettype wire

// File: tb/tb_gpr_sb.sv
// tb_gpr_sb: scoreboard bench driving directed and random traffic into gpr_sb.
`default_nettype none

module tb_gpr_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RN = 32;

  logic          clk = 1'b0;
  logic          rst, flush, wbu_valid, wbu_ready, wr_en;
  logic [AW-1:0] wr_id, rd_id_1, rd_id_2, iss_id;
  logic [DW-1:0] wr_data, rd_data_1, rd_data_2;
  logic          iss_valid, iss_wr_en, stall;
  logic [AW:0]   pend_cnt;

  always #5 clk = ~clk;

  gpr_sb dut (
    .i_sys_clk           (clk),
    .i_sys_rst           (rst),
    .i_sys_flush         (flush),
    .i_wbu_valid         (wbu_valid),
    .o_wbu_ready         (wbu_ready),
    .i_wbu_gpr_wr_en     (wr_en),
    .i_wbu_gpr_wr_id     (wr_id),
    .i_wbu_gpr_wr_data   (wr_data),
    .i_idu_gpr_rd_id_1   (rd_id_1),
    .i_idu_gpr_rd_id_2   (rd_id_2),
    .o_idu_gpr_rd_data_1 (rd_data_1),
    .o_idu_gpr_rd_data_2 (rd_data_2),
    .i_idu_issue_valid   (iss_valid),
    .i_idu_issue_wr_en   (iss_wr_en),
    .i_idu_issue_wr_id   (iss_id),
    .o_idu_stall         (stall),
    .o_gpr_pend_cnt      (pend_cnt)
  );

  typedef struct {
    bit          chk;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        st;
    logic        rdy;
    logic [5:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs[RN];
  bit          m_pend[RN];
  bit          m_ready;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  // Reference model: architectural values plus a set of outstanding destinations.
  function automatic logic [31:0] m_read(input int id, input bit w, input int wid, input logic [31:0] wd);
    if (id == 0)             return 32'h0;
    if (w && id == wid)      return wd;
    return m_regs[id];
  endfunction

  function automatic bit m_busy(input int id, input bit w, input int wid);
    return m_pend[id] && id != 0 && !(w && wid == id);
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < RN; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic step(input bit r, input bit f, input bit v, input bit we, input int wi,
                      input logic [31:0] wd, input int a1, input int a2,
                      input bit iv, input bit iwe, input int ii, input bit chk);
    exp_t e;
    bit   w, acc;
    rst = r; flush = f; wbu_valid = v; wr_en = we; wr_id = AW'(wi); wr_data = wd;
    rd_id_1 = AW'(a1); rd_id_2 = AW'(a2);
    iss_valid = iv; iss_wr_en = iwe; iss_id = AW'(ii);
    w      = v && m_ready && we && wi != 0;
    e.chk  = chk;
    e.d1   = m_read(a1, w, wi, wd);
    e.d2   = m_read(a2, w, wi, wd);
    e.st   = iv && (m_busy(a1, w, wi) || m_busy(a2, w, wi) || (iwe && m_busy(ii, w, wi)));
    e.rdy  = m_ready;
    e.cnt  = 6'(m_count());
    e.cyc  = cyc;
    sb.push_back(e);
    acc = iv && !e.st && !f;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < RN; i++) begin m_regs[i] = 32'h0; m_pend[i] = 1'b0; end
    end else begin
      if (w) m_regs[wi] = wd;
      if (f) begin
        for (int i = 0; i < RN; i++) m_pend[i] = 1'b0;
      end else begin
        if (w) m_pend[wi] = 1'b0;
        if (acc && iwe && ii != 0) m_pend[ii] = 1'b1;
      end
    end
    m_ready = !r;
    cyc++;
    #1;
  endtask

  task automatic idle(input int a1, input int a2);
    step(0, 0, 0, 0, 0, 32'h0, a1, a2, 0, 0, 0, 1);
  endtask

  function automatic int rid();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, RN - 1));
    return int'($urandom_range(0, 7));
  endfunction

  task automatic cmp(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, c, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          cmp("rd_data_1", e.cyc, rd_data_1, e.d1);
          cmp("rd_data_2", e.cyc, rd_data_2, e.d2);
          cmp("stall",     e.cyc, 32'(stall), 32'(e.st));
          cmp("wbu_ready", e.cyc, 32'(wbu_ready), 32'(e.rdy));
          cmp("pend_cnt",  e.cyc, 32'(pend_cnt), 32'(e.cnt));
        end
      end
    end
  end

  initial begin : driver
    m_ready = 1'b0;
    for (int i = 0; i < RN; i++) begin m_regs[i] = 32'h0; m_pend[i] = 1'b0; end
    rst = 1'b1; flush = 1'b0; wbu_valid = 1'b0; wr_en = 1'b0; wr_id = '0; wr_data = '0;
    rd_id_1 = '0; rd_id_2 = '0; iss_valid = 1'b0; iss_wr_en = 1'b0; iss_id = '0;
    @(posedge clk); #1;

    step(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 32'h0, 1, 2, 0, 0, 0, 1);
    // Basic write then read back, and x0 stays zero.
    step(0, 0, 1, 1, 1, 32'h1, 1, 0, 0, 0, 0, 1);
    idle(1, 0);
    step(0, 0, 1, 1, 0, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 1);
    idle(0, 1);
    // RAW hazard resolved by same-cycle writeback.
    step(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 5, 1);
    step(0, 0, 0, 0, 0, 32'h0, 5, 0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 5, 32'h8000_0000, 5, 0, 1, 0, 0, 1);
    idle(5, 0);
    // Set and clear of the same id in one cycle.
    step(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 3, 1);
    step(0, 0, 1, 1, 3, 32'h33, 3, 0, 1, 1, 3, 1);
    idle(3, 0);
    // Flush with a same-cycle commit and issue.
    step(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 2, 1);
    step(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 4, 1);
    step(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 6, 1);
    step(0, 1, 1, 1, 2, 32'h2, 2, 4, 1, 1, 8, 1);
    step(0, 0, 0, 0, 0, 32'h0, 2, 6, 1, 1, 4, 1);
    step(0, 0, 0, 0, 0, 32'h0, 8, 4, 1, 0, 0, 1);
    // Reset in the middle of activity.
    step(0, 0, 1, 1, 7, 32'h7, 7, 0, 1, 1, 9, 1);
    step(0, 0, 0, 0, 0, 32'h0, 7, 0, 1, 1, 10, 1);
    step(1, 1, 1, 1, 11, 32'hB, 7, 9, 1, 1, 12, 1);
    step(0, 0, 0, 0, 0, 32'h0, 7, 9, 1, 1, 10, 1);
    idle(7, 10);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0, rid(), $urandom(),
           rid(), rid(), $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, rid(), 1);
    end

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
